flag_branch_unit: RTL and testbench
===================================

// Module: flag_branch_unit
// PURPOSE
//  Sits directly downstream of the 16-bit execute-stage ALU. Holds the architectural N/V/Z flag register.
//  - Captures alu_nvz from the instruction in EX, using a per-opcode update mask.
//  - Evaluates the 3-bit branch condition of the instruction in ID against those flags.
//  - Resolves the EX->ID flag dependency in one of two ways: forwarding (FORWARD=1) or a hazard stall request (FORWARD=0).
// PARAMETERS
//  FORWARD      1       1: branch evaluates against next-cycle flags; 0: raise br_hazard instead
//  RESET_FLAGS  3'b000  {N,V,Z} value loaded on reset
// PORTS
//  clk          in   1  system clock; all state on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  ex_valid     in   1  EX stage holds a live instruction
//  ex_opcode    in   4  opcode of EX instruction; ALU ops have ex_opcode[3]=0
//  alu_nvz      in   3  {N,V,Z} from ALU for EX instruction
//  stall        in   1  pipeline hold; no flag update while high
//  flush        in   1  kill EX instruction; suppresses its flag update
//  br_valid     in   1  ID stage holds a conditional branch (B or BR)
//  br_ccc       in   3  branch condition code
//  flags        out  3  registered {N,V,Z}
//  br_taken     out  1  combinational branch decision for ID instruction
//  br_hazard    out  1  FORWARD=0 only: ID branch must stall one cycle (tied 0 if FORWARD=1)
//  flag_wr      out  1  registered: flags were written on the previous edge (debug/trace)
// BEHAVIOUR
//  Reset (async, rst_n=0): flags=RESET_FLAGS, flag_wr=0. Outputs are live the cycle rst_n deasserts.
//  Update mask by ex_opcode (bits {N,V,Z}):
//   ADD 0000 / SUB 0001: 111
//   XOR 0010, SLL 0100, SRA 0101, ROR 0110: 001 (Z only)
//   RED 0011, PADDSB 0111: 000
//   any ex_opcode[3]=1: 000
//  wr_en = ex_valid & ~stall & ~flush & (mask!=0).
//  Next flags: F_next[i] = (wr_en & mask[i]) ? alu_nvz[i] : flags[i]. flags<=F_next every edge.
//  flag_wr <= wr_en.
//  flush has priority over stall. Both high => no update; flags hold.
//  Condition table (ccc -> taken), with {N,V,Z} taken from Fe:
//   000 NE: Z=0
//   001 EQ: Z=1
//   010 GT: Z=0 & N=0
//   011 LT: N=1
//   100 GE: Z=1 | (Z=0 & N=0)
//   101 LE: N=1 | Z=1
//   110 OV: V=1
//   111 UN: 1
//  FORWARD=1: Fe=F_next, computed with stall/flush ignored (EX result is final).
//   br_taken = br_valid & cond(Fe). br_hazard=0.
//  FORWARD=0: Fe=flags.
//   br_hazard = br_valid & ex_valid & ~flush & (mask!=0).
//   br_taken = br_valid & ~br_hazard & cond(flags).
//  br_valid=0 => br_taken=0 regardless of ccc.
//  Mask covers only the flags that actually change: under forwarding, an ID branch after an EX XOR
//   sees the new Z and the old N,V.
//  Reset mid-stall or mid-flush: flags go to RESET_FLAGS immediately; nothing pending is retained.
//  No internal pipelining beyond the flag and flag_wr registers. Latency:
//   flags visible one edge after the EX cycle.
//   br_taken combinational, same cycle.
// TESTING
//  Reset: rst_n=0 mid-cycle with ex_valid=1 -> flags=000 and flag_wr=0 asynchronously, no update.
//  SUB, alu_nvz=110 -> flags=110 after 1 edge, flag_wr=1. Then XOR, alu_nvz=001 -> flags=111.
//  PADDSB/RED with alu_nvz=001, and opcode 1000 -> flags unchanged, flag_wr=0.
//  stall=1 or flush=1 with ADD, alu_nvz=010 -> flags unchanged for the whole hold.
//   Release stall -> update on that edge.
//  FORWARD=1, flags=000: EX ADD alu_nvz=001 plus ID br_ccc=001 same cycle -> br_taken=1.
//   Sweep all 8 ccc x 8 flag values against the table.
//  FORWARD=0, same stimulus -> br_hazard=1, br_taken=0. Next cycle with ex_valid=0 -> br_taken=1, br_hazard=0.

Source files
------------

// File: rtl/flag_branch_unit.sv
// N/V/Z flag register fed by the EX-stage ALU, plus branch-condition evaluation
// for the instruction in ID, with either flag forwarding or a one-cycle hazard stall.
module flag_branch_unit #(
   parameter bit         FORWARD     = 1'b1,
   parameter logic [2:0] RESET_FLAGS = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic [3:0] ex_opcode,
   input  logic [2:0] alu_nvz,
   input  logic       stall,
   input  logic       flush,
   input  logic       br_valid,
   input  logic [2:0] br_ccc,
   output logic [2:0] flags,
   output logic       br_taken,
   output logic       br_hazard,
   output logic       flag_wr
);

   typedef enum logic [3:0] {
      OP_ADD    = 4'b0000,
      OP_SUB    = 4'b0001,
      OP_XOR    = 4'b0010,
      OP_RED    = 4'b0011,
      OP_SLL    = 4'b0100,
      OP_SRA    = 4'b0101,
      OP_ROR    = 4'b0110,
      OP_PADDSB = 4'b0111
   } alu_op_e;

   typedef enum logic [2:0] {
      CC_NE = 3'b000,
      CC_EQ = 3'b001,
      CC_GT = 3'b010,
      CC_LT = 3'b011,
      CC_GE = 3'b100,
      CC_LE = 3'b101,
      CC_OV = 3'b110,
      CC_UN = 3'b111
   } cond_e;

   // nvz layout: [2]=N, [1]=V, [0]=Z
   function automatic logic cond_eval(input logic [2:0] ccc, input logic [2:0] nvz);
      logic taken;
      taken = 1'b0;
      case (ccc)
         CC_NE:   taken = ~nvz[0];
         CC_EQ:   taken =  nvz[0];
         CC_GT:   taken = ~nvz[0] & ~nvz[2];
         CC_LT:   taken =  nvz[2];
         CC_GE:   taken =  nvz[0] | ~nvz[2];
         CC_LE:   taken =  nvz[2] | nvz[0];
         CC_OV:   taken =  nvz[1];
         CC_UN:   taken =  1'b1;
         default: taken =  1'b0;
      endcase
      return taken;
   endfunction

   logic [2:0] flags_q, flags_d;
   logic       flag_wr_q;
   logic [2:0] upd_mask;
   logic       has_upd;
   logic       wr_en;
   logic [2:0] fwd_nvz;
   logic       br_taken_c;
   logic       br_hazard_c;

   always_comb begin
      upd_mask = '0;
      case (ex_opcode)
         OP_ADD, OP_SUB:                 upd_mask = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_mask = 3'b001;
         default:                        upd_mask = '0;
      endcase
   end

   assign has_upd = |upd_mask;
   assign wr_en   = ex_valid & ~stall & ~flush & has_upd;

   // Only masked bits take the ALU value; the rest keep their architectural state.
   always_comb begin
      flags_d = flags_q;
      fwd_nvz = flags_q;
      if (wr_en)
         flags_d = (flags_q & ~upd_mask) | (alu_nvz & upd_mask);
      // Forwarded view ignores stall/flush: the EX result is already final.
      if (ex_valid)
         fwd_nvz = (flags_q & ~upd_mask) | (alu_nvz & upd_mask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q   <= RESET_FLAGS;
         flag_wr_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         flag_wr_q <= wr_en;
      end
   end

   always_comb begin
      br_taken_c  = 1'b0;
      br_hazard_c = 1'b0;
      if (FORWARD) begin
         br_taken_c = br_valid & cond_eval(br_ccc, fwd_nvz);
      end else begin
         br_hazard_c = br_valid & ex_valid & ~flush & has_upd;
         br_taken_c  = br_valid & ~br_hazard_c & cond_eval(br_ccc, flags_q);
      end
   end

   assign flags     = flags_q;
   assign flag_wr   = flag_wr_q;
   assign br_taken  = br_taken_c;
   assign br_hazard = br_hazard_c;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench: one forwarding and one stalling instance driven from the same inputs.
module tb_flag_branch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ex_valid;
   logic [3:0] ex_opcode;
   logic [2:0] alu_nvz;
   logic       stall;
   logic       flush;
   logic       br_valid;
   logic [2:0] br_ccc;

   logic [2:0] f_flags, s_flags;
   logic       f_taken, s_taken;
   logic       f_haz, s_haz;
   logic       f_wr, s_wr;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   flag_branch_unit #(.FORWARD(1'b1), .RESET_FLAGS(3'b000)) u_fwd (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .alu_nvz(alu_nvz), .stall(stall), .flush(flush), .br_valid(br_valid),
      .br_ccc(br_ccc), .flags(f_flags), .br_taken(f_taken), .br_hazard(f_haz),
      .flag_wr(f_wr)
   );

   flag_branch_unit #(.FORWARD(1'b0), .RESET_FLAGS(3'b000)) u_stl (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .alu_nvz(alu_nvz), .stall(stall), .flush(flush), .br_valid(br_valid),
      .br_ccc(br_ccc), .flags(s_flags), .br_taken(s_taken), .br_hazard(s_haz),
      .flag_wr(s_wr)
   );

   function automatic logic exp_taken(input logic [2:0] ccc, input logic [2:0] f);
      logic n, v, z;
      n = f[2];
      v = f[1];
      z = f[0];
      case (ccc)
         3'd0:    return !z;
         3'd1:    return z;
         3'd2:    return !z && !n;
         3'd3:    return n;
         3'd4:    return z || (!z && !n);
         3'd5:    return n || z;
         3'd6:    return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input logic v, input logic [3:0] op, input logic [2:0] nvz);
      ex_valid  = v;
      ex_opcode = op;
      alu_nvz   = nvz;
   endtask

   task automatic flag_state(input string tag, input logic [2:0] f, input logic wr);
      check({tag, "_flags"}, f_flags, f);
      check({tag, "_wr"}, {2'b00, f_wr}, {2'b00, wr});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      ex(1'b0, 4'b0000, 3'b000);
      stall = 1'b0; flush = 1'b0; br_valid = 1'b0; br_ccc = 3'b000;
      #2;
      flag_state("rst", 3'b000, 1'b0);
      check("rst_stl_flags", s_flags, 3'b000);

      // Live EX instruction while reset is held must not update
      ex(1'b1, 4'b0000, 3'b111);
      tick();
      flag_state("rst_hold", 3'b000, 1'b0);
      rst_n = 1'b1;

      ex(1'b1, 4'b0001, 3'b110); tick(); flag_state("sub", 3'b110, 1'b1);
      ex(1'b1, 4'b0010, 3'b001); tick(); flag_state("xor", 3'b111, 1'b1);
      check("xor_stl_flags", s_flags, 3'b111);

      // Asynchronous reset mid-cycle
      ex(1'b1, 4'b0000, 3'b000);
      #2; rst_n = 1'b0; #1;
      flag_state("arst", 3'b000, 1'b0);
      check("arst_stl_flags", s_flags, 3'b000);
      tick();
      flag_state("arst_hold", 3'b000, 1'b0);
      rst_n = 1'b1;

      ex(1'b1, 4'b0111, 3'b001); tick(); flag_state("paddsb", 3'b000, 1'b0);
      ex(1'b1, 4'b0011, 3'b001); tick(); flag_state("red", 3'b000, 1'b0);
      ex(1'b1, 4'b1000, 3'b111); tick(); flag_state("op1000", 3'b000, 1'b0);
      ex(1'b1, 4'b1111, 3'b111); tick(); flag_state("op1111", 3'b000, 1'b0);
      ex(1'b1, 4'b0100, 3'b111); tick(); flag_state("sll", 3'b001, 1'b1);
      ex(1'b1, 4'b0110, 3'b110); tick(); flag_state("ror", 3'b000, 1'b1);
      ex(1'b1, 4'b0101, 3'b011); tick(); flag_state("sra", 3'b001, 1'b1);

      ex(1'b1, 4'b0000, 3'b101); tick(); flag_state("add", 3'b101, 1'b1);
      stall = 1'b1; ex(1'b1, 4'b0000, 3'b010);
      tick(); flag_state("stall1", 3'b101, 1'b0);
      tick(); flag_state("stall2", 3'b101, 1'b0);
      stall = 1'b0;
      tick(); flag_state("stall_rel", 3'b010, 1'b1);
      flush = 1'b1; ex(1'b1, 4'b0000, 3'b101);
      tick(); flag_state("flush1", 3'b010, 1'b0);
      tick(); flag_state("flush2", 3'b010, 1'b0);
      stall = 1'b1;
      tick(); flag_state("stall_flush", 3'b010, 1'b0);
      stall = 1'b0; flush = 1'b0;
      tick(); flag_state("flush_rel", 3'b101, 1'b1);

      // XOR forwards only Z; N and V come from the register
      ex(1'b1, 4'b0001, 3'b110); tick(); flag_state("sub2", 3'b110, 1'b1);
      ex(1'b1, 4'b0010, 3'b001); br_valid = 1'b1;
      br_ccc = 3'b110; #1;
      check("xor_fwd_ov", {2'b00, f_taken}, 3'b001);
      check("xor_stl_haz", {2'b00, s_haz}, 3'b001);
      check("xor_stl_tk", {2'b00, s_taken}, 3'b000);
      br_ccc = 3'b000; #1;
      check("xor_fwd_ne", {2'b00, f_taken}, 3'b000);
      tick();
      check("xor2_flags", f_flags, 3'b111);

      ex(1'b1, 4'b0111, 3'b000); br_ccc = 3'b001; #1;
      check("paddsb_stl_haz", {2'b00, s_haz}, 3'b000);
      check("paddsb_stl_tk", {2'b00, s_taken}, 3'b001);
      check("paddsb_fwd_tk", {2'b00, f_taken}, 3'b001);
      flush = 1'b1; ex(1'b1, 4'b0000, 3'b000); #1;
      check("flush_stl_haz", {2'b00, s_haz}, 3'b000);
      check("flush_stl_tk", {2'b00, s_taken}, 3'b001);
      check("flush_fwd_tk", {2'b00, f_taken}, 3'b000);
      flush = 1'b0;
      br_valid = 1'b0; br_ccc = 3'b111; #1;
      check("nobr_fwd_tk", {2'b00, f_taken}, 3'b000);
      check("nobr_stl_tk", {2'b00, s_taken}, 3'b000);
      check("nobr_stl_haz", {2'b00, s_haz}, 3'b000);

      ex(1'b1, 4'b0000, 3'b000); tick(); flag_state("clr", 3'b000, 1'b1);
      ex(1'b1, 4'b0000, 3'b001); br_valid = 1'b1; br_ccc = 3'b001; #1;
      check("eq_fwd_tk", {2'b00, f_taken}, 3'b001);
      check("eq_fwd_haz", {2'b00, f_haz}, 3'b000);
      check("eq_stl_haz", {2'b00, s_haz}, 3'b001);
      check("eq_stl_tk", {2'b00, s_taken}, 3'b000);
      tick();
      ex(1'b0, 4'b0000, 3'b000); #1;
      check("eq_next_stl_tk", {2'b00, s_taken}, 3'b001);
      check("eq_next_stl_haz", {2'b00, s_haz}, 3'b000);
      check("eq_next_fwd_tk", {2'b00, f_taken}, 3'b001);

      for (int v = 0; v < 8; v++) begin
         logic [2:0] fv, inv;
         fv  = 3'(v);
         inv = ~fv;
         br_valid = 1'b0; stall = 1'b0;
         ex(1'b1, 4'b0000, fv); tick();
         check("sweep_load", f_flags, fv);
         ex(1'b0, 4'b0000, 3'b000); br_valid = 1'b1;
         for (int c = 0; c < 8; c++) begin
            br_ccc = 3'(c); #1;
            check("sweep_fwd_reg", {2'b00, f_taken}, {2'b00, exp_taken(br_ccc, fv)});
            check("sweep_stl_reg", {2'b00, s_taken}, {2'b00, exp_taken(br_ccc, fv)});
         end
         stall = 1'b1; ex(1'b1, 4'b0000, inv);
         for (int c = 0; c < 8; c++) begin
            br_ccc = 3'(c); #1;
            check("sweep_fwd_ex", {2'b00, f_taken}, {2'b00, exp_taken(br_ccc, inv)});
            check("sweep_stl_haz", {2'b00, s_haz}, 3'b001);
            check("sweep_stl_tk", {2'b00, s_taken}, 3'b000);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
